alu_wb_sel: RTL and testbench

Registered, parametrised successor to the ALU result multiplexer. It accepts one operation per cycle over a valid/ready handshake and selects the result source (ALU, shifter, HI, LO) from the 6-bit function code. It holds the result in an output register until the writeback stage takes it. MFHI/MFLO are interlocked against an in-flight MULTU so they never return a stale HI/LO value. It sits between the ALU/shifter/HI-LO datapath and the register-file writeback port.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/wb_src_decode.sv | 36 +++
 rtl/alu_wb_sel.sv | 118 +++++++++++
 tb/tb_alu_wb_sel.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the writeback result selector.
//   - function codes understood by the selector
//   - src_sel encodings (which datapath produced data_out)
//   - selector state encoding
package alu_pkg;

  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_FIRST = 6'd62;

  typedef enum logic [1:0] {
    SRC_ALU   = 2'd0,
    SRC_SHIFT = 2'd1,
    SRC_HI    = 2'd2,
    SRC_LO    = 2'd3
  } src_sel_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/wb_src_decode.sv
// wb_src_decode: combinational decode of the 6-bit function code.
// Ports:
//   signal     in   function code
//   src_sel    out  result source (ALU, shifter, HI, LO)
//   no_result  out  op is accepted but produces no output beat
//   needs_hilo out  op reads HI/LO and must wait for the multiplier
module wb_src_decode
  import alu_pkg::*;
(
  input  logic [5:0] signal,
  output src_sel_t   src_sel,
  output logic       no_result,
  output logic       needs_hilo
);

  always_comb begin
    src_sel    = SRC_ALU;
    no_result  = 1'b0;
    needs_hilo = 1'b0;
    case (signal)
      FN_MFHI: begin
        src_sel    = SRC_HI;
        needs_hilo = 1'b1;
      end
      FN_MFLO: begin
        src_sel    = SRC_LO;
        needs_hilo = 1'b1;
      end
      FN_SLL, FN_SRL: src_sel = SRC_SHIFT;
      FN_MULTU, FN_FIRST: no_result = 1'b1;
      // All remaining codes, defined or not, take the ALU result.
      default: src_sel = SRC_ALU;
    endcase
  end

endmodule

// File: rtl/alu_wb_sel.sv
// alu_wb_sel: registered result selector between the ALU/shifter/HI-LO
// datapath and the register-file writeback port.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      operation handshake (signal + data inputs)
//   signal                 function code
//   alu_out, shifter_out   datapath results
//   hi_out, lo_out         HI/LO registers
//   mul_busy               multiplier still writing HI/LO
//   out_valid/out_ready    result handshake towards writeback
//   data_out, src_sel      registered result and its source
//   stall_cnt              saturating count of cycles spent waiting on HI/LO
module alu_wb_sel
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        signal,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] shifter_out,
  input  logic [DATA_W-1:0] hi_out,
  input  logic [DATA_W-1:0] lo_out,
  input  logic              mul_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        src_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            state_reg;
  src_sel_t          src_reg;
  src_sel_t          pend_reg;   // HI or LO source remembered while in WAIT
  logic [DATA_W-1:0] data_reg;
  logic [CNT_W-1:0]  stall_reg;

  src_sel_t          dec_sel;
  logic              dec_no_result;
  logic              dec_needs_hilo;

  src_sel_t          cap_sel;
  logic [DATA_W-1:0] cap_data;
  logic              accept;

  wb_src_decode u_decode (
    .signal     (signal),
    .src_sel    (dec_sel),
    .no_result  (dec_no_result),
    .needs_hilo (dec_needs_hilo)
  );

  // in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready  = (state_reg == ST_EMPTY) || ((state_reg == ST_FULL) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == ST_FULL);
  assign data_out  = data_reg;
  assign src_sel   = src_reg;
  assign stall_cnt = stall_reg;

  // One capture mux: in WAIT the latched HI/LO choice drives it, otherwise
  // the freshly decoded code does.
  always_comb begin
    cap_sel = (state_reg == ST_WAIT) ? pend_reg : dec_sel;
    case (cap_sel)
      SRC_SHIFT: cap_data = shifter_out;
      SRC_HI:    cap_data = hi_out;
      SRC_LO:    cap_data = lo_out;
      default:   cap_data = alu_out;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      src_reg   <= SRC_ALU;
      pend_reg  <= SRC_ALU;
      data_reg  <= '0;
      stall_reg <= '0;
    end else begin
      case (state_reg)
        ST_EMPTY, ST_FULL: begin
          if (accept) begin
            if (dec_no_result) begin
              state_reg <= ST_EMPTY;
            end else if (dec_needs_hilo && mul_busy) begin
              state_reg <= ST_WAIT;
              pend_reg  <= dec_sel;
            end else begin
              state_reg <= ST_FULL;
              data_reg  <= cap_data;
              src_reg   <= cap_sel;
            end
          end else if ((state_reg == ST_FULL) && out_ready) begin
            state_reg <= ST_EMPTY;
          end
        end
        ST_WAIT: begin
          if (mul_busy) begin
            if (stall_reg != {CNT_W{1'b1}}) begin
              stall_reg <= stall_reg + CNT_W'(1);
            end
          end else begin
            state_reg <= ST_FULL;
            data_reg  <= cap_data;
            src_reg   <= cap_sel;
          end
        end
        default: state_reg <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wb_sel.sv
module tb_alu_wb_sel;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    signal = '0;
  logic [DW-1:0] alu_out = '0;
  logic [DW-1:0] shifter_out = '0;
  logic [DW-1:0] hi_out = '0;
  logic [DW-1:0] lo_out = '0;
  logic          mul_busy = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] data_out;
  logic [1:0]    src_sel;
  logic [CW-1:0] stall_cnt;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  src;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  alu_wb_sel #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .signal      (signal),
    .alu_out     (alu_out),
    .shifter_out (shifter_out),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .mul_busy    (mul_busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .src_sel     (src_sel),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] code);
    in_valid = 1'b1;
    signal   = code;
  endtask

  // Monitor: a beat happens at the next rising edge when out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data 0x%08h src %0d, expected no beat", data_out, src_sel);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("beat data=0x%08h src=%0d (expected 0x%08h src %0d)", data_out, src_sel, e.data, e.src);
        chk("beat_data", data_out, e.data);
        chk("beat_src", {30'b0, src_sel}, {30'b0, e.src});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_src", {30'b0, src_sel}, 32'd0);
    chk("rst_stall", {29'b0, stall_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ADD: result visible the cycle after acceptance, then drains
    out_ready = 1'b1;
    issue(FN_ADD); alu_out = 32'h5;
    q.push_back('{32'h5, 2'd0});
    tick();
    in_valid = 1'b0;
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    tick();
    chk("add_drained", {31'b0, out_valid}, 32'd0);

    // Back-to-back SLL, SRL, OR with in_ready held high
    issue(FN_SLL); shifter_out = 32'h10;
    q.push_back('{32'h10, 2'd1});
    tick();
    chk("b2b_ready0", {31'b0, in_ready}, 32'd1);
    issue(FN_SRL); shifter_out = 32'h20;
    q.push_back('{32'h20, 2'd1});
    tick();
    chk("b2b_ready1", {31'b0, in_ready}, 32'd1);
    issue(FN_OR); alu_out = 32'h30;
    q.push_back('{32'h30, 2'd0});
    tick();
    chk("b2b_ready2", {31'b0, in_ready}, 32'd1);

    // MULTU and FIRST give no beat (monitor flags any beat); MFHI waits
    issue(FN_MULTU);
    tick();
    chk("multu_nobeat", {31'b0, out_valid}, 32'd0);
    issue(FN_FIRST);
    tick();
    chk("first_nobeat", {31'b0, out_valid}, 32'd0);
    issue(FN_MFHI); mul_busy = 1'b1; hi_out = 32'h0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wait_in_ready", {31'b0, in_ready}, 32'd0);
      chk("wait_out_valid", {31'b0, out_valid}, 32'd0);
      tick();
    end
    chk("wait_stall4", {29'b0, stall_cnt}, 32'd4);
    mul_busy = 1'b0; hi_out = 32'hDEADBEEF;
    q.push_back('{32'hDEADBEEF, 2'd2});
    chk("wait_last_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("mfhi_valid", {31'b0, out_valid}, 32'd1);
    hi_out = 32'h0;
    tick();

    // MFLO held under back-pressure
    out_ready = 1'b0;
    issue(FN_MFLO); lo_out = 32'h1234;
    q.push_back('{32'h1234, 2'd3});
    tick();
    in_valid = 1'b0; lo_out = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_data", data_out, 32'h1234);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("hold_drained", {31'b0, out_valid}, 32'd0);

    // Undefined code falls through to ALU
    issue(6'h3F); alu_out = 32'hA5A5A5A5;
    q.push_back('{32'hA5A5A5A5, 2'd0});
    tick();
    in_valid = 1'b0;
    tick();

    // Stall counter saturates (3-bit counter: 4 + 10 -> 7)
    issue(FN_MFHI); mul_busy = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("stall_sat", {29'b0, stall_cnt}, 32'd7);
    mul_busy = 1'b0; hi_out = 32'h11;
    q.push_back('{32'h11, 2'd2});
    tick();
    tick();

    // Reset while FULL drops the held result
    out_ready = 1'b0;
    issue(FN_ADD); alu_out = 32'h77;
    q.push_back('{32'h77, 2'd0});
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_data", data_out, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_stall", {29'b0, stall_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_nobeat", {31'b0, out_valid}, 32'd0);
    end

    chk("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
